arith_issue_arbiter: RTL and testbench
======================================

// Module: arith_issue_arbiter
// PURPOSE
//  Shares one ArithmaticUnit between two issue requesters (A, B) with a
//  round-robin valid/ready arbiter. Registers the granted op onto the AU input
//  bus. Holds off grants while a multiply occupies the unit. Tags each AU
//  result with its owning requester, aligned to the AU writeback outputs.
// PARAMETERS
//  DATA_W     16  operand width; must match the AU
//  MUL_STALL   1  extra no-grant cycles after a mul issue (0..15)
// PORTS
//  clock_i           in   1   clock
//  reset_i           in   1   synchronous reset, active-high
//  aValid_i/bValid_i in   1   requester has an op
//  aReady_o/bReady_o out  1   op accepted when valid&ready on the same edge
//  aOpCode_i/bOpCode_i in 7   0 nop, 1 add, 2 sub, 3 mul
//  aPOp_i/bPOp_i     in   DATA_W  primary operand
//  aSOp_i/bSOp_i     in   DATA_W  secondary operand
//  aWbAddr_i/bWbAddr_i in 5   destination register
//  aIsWb_i/bIsWb_i   in   1   op writes back
//  auEnable_o        out  1   AU enable_i
//  auOpCode_o        out  7   AU opCode_i
//  auPOp_o/auSOp_o   out  DATA_W  AU operands
//  auWbAddr_o        out  5   AU wbAddress_i
//  auIsWb_o          out  1   AU isWb_i
//  resOwner_o        out  1   0=A, 1=B; valid with resValid_o
//  resValid_o        out  1   AU wb outputs this cycle belong to resOwner_o
//  illegalOp_o       out  1   1-cycle pulse: accepted op had opcode>3
//  busy_o            out  1   in BUSY state (mul stall)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rrPtr=0 (A favoured); stall cnt 0;
//   owner pipeline cleared. Reset mid-stall aborts stall; in-flight tags drop.
//  States: IDLE (grants allowed), BUSY (no grants, counting MUL_STALL).
//  Ready (combinational, IDLE only, never depends on own valid):
//   only A valid -> aReady=1; only B valid -> bReady=1;
//   both valid -> grant rrPtr side only; neither -> both ready=0.
//   BUSY -> aReady=bReady=0.
//  rrPtr flips to the non-granted side after every grant; unchanged if none.
//  Issue: on accept edge, au* register the granted fields, auEnable_o=1 next
//   cycle; cycles without accept -> auEnable_o=0, other au* hold.
//  Opcode>3: accepted, NOT issued (auEnable_o=0), illegalOp_o=1 next cycle,
//   rrPtr still flips, no resValid.
//  Opcode 0 (nop): issued normally; resValid_o stays 0 for it.
//  Mul (3) accepted with MUL_STALL>0 -> BUSY for exactly MUL_STALL cycles
//   after the accept edge, then IDLE; MUL_STALL=0 never enters BUSY.
//  Latency: accept at edge N -> auEnable_o high after N -> AU result after N+1;
//   resValid_o/resOwner_o asserted after N+1, for one cycle, when op in
//   {1,2,3} and isWb=1.
//  Back-to-back: one accept per cycle max; sustained add/sub = 1 op/cycle.
//  Widths: pass-through only; no arithmetic here.
// TESTING
//  1 A only, add 3+4 wb r5, 4 cycles -> aReady=1 every cycle, auEnable 1 after
//    each accept, resValid/resOwner=0 two edges after each accept.
//  2 A,B both valid adds for 6 cycles -> grants A,B,A,B,A,B;
//    resOwner 0,1,0,1,0,1.
//  3 A mul 7*6, MUL_STALL=1, B valid -> next cycle busy_o=1, bReady=0;
//    B granted the cycle after; AU sees mul then B op.
//  4 B opcode 9 -> accepted, auEnable stays 0, illegalOp_o pulses once,
//    next tie goes to A.
//  5 reset_i=1 during BUSY with a tag in flight -> next cycle all outputs 0,
//    busy_o=0, resValid_o=0, rrPtr=A.
//  6 A nop with isWb=1 -> auEnable=1, auOpCode=0, resValid_o stays 0.

Source files
------------

// File: rtl/arith_issue_arbiter_if.sv
// Issue-side bundle: two requester ports, the AU input bus and the tagged-result/status outputs.
// The slave modport is the arbiter; the master modport drives the requesters and observes the AU side.
interface arith_issue_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              aValid_i, bValid_i;
  logic              aReady_o, bReady_o;
  logic [6:0]        aOpCode_i, bOpCode_i;
  logic [DATA_W-1:0] aPOp_i, bPOp_i, aSOp_i, bSOp_i;
  logic [4:0]        aWbAddr_i, bWbAddr_i;
  logic              aIsWb_i, bIsWb_i;
  logic              auEnable_o;
  logic [6:0]        auOpCode_o;
  logic [DATA_W-1:0] auPOp_o, auSOp_o;
  logic [4:0]        auWbAddr_o;
  logic              auIsWb_o;
  logic              resOwner_o, resValid_o;
  logic              illegalOp_o, busy_o;

  modport slave (
    input  aValid_i, bValid_i, aOpCode_i, bOpCode_i, aPOp_i, bPOp_i,
           aSOp_i, bSOp_i, aWbAddr_i, bWbAddr_i, aIsWb_i, bIsWb_i,
    output aReady_o, bReady_o, auEnable_o, auOpCode_o, auPOp_o, auSOp_o,
           auWbAddr_o, auIsWb_o, resOwner_o, resValid_o, illegalOp_o, busy_o
  );

  modport master (
    output aValid_i, bValid_i, aOpCode_i, bOpCode_i, aPOp_i, bPOp_i,
           aSOp_i, bSOp_i, aWbAddr_i, bWbAddr_i, aIsWb_i, bIsWb_i,
    input  aReady_o, bReady_o, auEnable_o, auOpCode_o, auPOp_o, auSOp_o,
           auWbAddr_o, auIsWb_o, resOwner_o, resValid_o, illegalOp_o, busy_o
  );
endinterface

// File: rtl/arith_issue_arbiter.sv
// Round-robin arbiter sharing one AU between requesters A and B; issue registered (1 cycle),
// result tag 2 cycles after accept; no grants while a multiply holds the unit in BUSY.
module arith_issue_arbiter #(
  parameter int DATA_W    = 16,
  parameter int MUL_STALL = 1
) (
  input  logic clock_i,
  input  logic reset_i,
  arith_issue_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q;
  logic              rr_q, rr_d;
  logic [3:0]        stall_q;
  logic              en_q, iswb_q, ill_q;
  logic [6:0]        op_q;
  logic [DATA_W-1:0] pop_q, sop_q;
  logic [4:0]        wb_q;
  logic              pend_vld_q, pend_own_q, res_vld_q, res_own_q;

  logic              idle, a_rdy, b_rdy, acc, legal, issue;
  logic [6:0]        sel_op;
  logic [DATA_W-1:0] sel_pop, sel_sop;
  logic [4:0]        sel_wb;
  logic              sel_iswb;

  // rr_q=0 favours A on a tie, rr_q=1 favours B.
  assign idle  = (state_q == IDLE);
  assign a_rdy = idle & bus.aValid_i & (~bus.bValid_i | ~rr_q);
  assign b_rdy = idle & bus.bValid_i & (~bus.aValid_i |  rr_q);
  assign acc   = a_rdy | b_rdy;

  always_comb begin
    sel_op   = bus.aOpCode_i;
    sel_pop  = bus.aPOp_i;
    sel_sop  = bus.aSOp_i;
    sel_wb   = bus.aWbAddr_i;
    sel_iswb = bus.aIsWb_i;
    if (b_rdy) begin
      sel_op   = bus.bOpCode_i;
      sel_pop  = bus.bPOp_i;
      sel_sop  = bus.bSOp_i;
      sel_wb   = bus.bWbAddr_i;
      sel_iswb = bus.bIsWb_i;
    end
  end

  assign legal = (sel_op[6:2] == 5'd0);
  assign issue = acc & legal;
  assign rr_d  = acc ? a_rdy : rr_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      stall_q    <= 4'd0;
      en_q       <= 1'b0;
      op_q       <= 7'd0;
      pop_q      <= '0;
      sop_q      <= '0;
      wb_q       <= 5'd0;
      iswb_q     <= 1'b0;
      ill_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_own_q <= 1'b0;
      res_vld_q  <= 1'b0;
      res_own_q  <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      en_q       <= issue;
      ill_q      <= acc & ~legal;
      pend_vld_q <= issue & (sel_op != 7'd0) & sel_iswb;
      pend_own_q <= b_rdy;
      res_vld_q  <= pend_vld_q;
      res_own_q  <= pend_own_q;
      if (issue) begin
        op_q   <= sel_op;
        pop_q  <= sel_pop;
        sop_q  <= sel_sop;
        wb_q   <= sel_wb;
        iswb_q <= sel_iswb;
      end
      case (state_q)
        IDLE: if (issue && sel_op == 7'd3 && MUL_STALL > 0) begin
          state_q <= BUSY;
          stall_q <= 4'(MUL_STALL - 1);
        end
        BUSY: begin
          if (stall_q == 4'd0) state_q <= IDLE;
          else                 stall_q <= stall_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.aReady_o    = a_rdy;
  assign bus.bReady_o    = b_rdy;
  assign bus.auEnable_o  = en_q;
  assign bus.auOpCode_o  = op_q;
  assign bus.auPOp_o     = pop_q;
  assign bus.auSOp_o     = sop_q;
  assign bus.auWbAddr_o  = wb_q;
  assign bus.auIsWb_o    = iswb_q;
  assign bus.resValid_o  = res_vld_q;
  assign bus.resOwner_o  = res_own_q;
  assign bus.illegalOp_o = ill_q;
  assign bus.busy_o      = (state_q == BUSY);
endmodule

// File: tb/tb_arith_issue_arbiter.sv
// Directed scenarios followed by random traffic, each cycle compared against a cycle-indexed
// transaction model (grant rule, busy window, result due-times).
module tb_arith_issue_arbiter;
  localparam int DW = 16;
  localparam int MS = 1;

  typedef struct packed {
    logic          vld;
    logic [6:0]    op;
    logic [DW-1:0] p;
    logic [DW-1:0] s;
    logic [4:0]    wb;
    logic          iswb;
  } req_t;

  typedef struct {
    int   due;
    logic own;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arith_issue_arbiter_if #(.DATA_W(DW)) bus ();
  arith_issue_arbiter #(.DATA_W(DW), .MUL_STALL(MS)) dut (
    .clock_i(clk), .reset_i(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: edges elapsed, tie-break side, edge index at which BUSY ends, pending results.
  int   e = 0;
  int   busy_end = 0;
  logic m_rr = 1'b0;
  res_t rq[$];
  logic          x_en = 0, x_ill = 0, x_iswb = 0;
  logic [6:0]    x_op = 0;
  logic [DW-1:0] x_pop = 0, x_sop = 0;
  logic [4:0]    x_wb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic req_t mk(input logic v, input int op, input int p, input int s,
                              input int wb, input logic iswb);
    req_t r;
    r.vld = v; r.op = 7'(op); r.p = DW'(p); r.s = DW'(s); r.wb = 5'(wb); r.iswb = iswb;
    return r;
  endfunction

  task automatic step(input req_t a, input req_t b, input logic r);
    logic idle, ea, eb, own, resv;
    req_t g;
    @(negedge clk);
    rst = r;
    bus.aValid_i = a.vld; bus.aOpCode_i = a.op; bus.aPOp_i = a.p; bus.aSOp_i = a.s;
    bus.aWbAddr_i = a.wb; bus.aIsWb_i = a.iswb;
    bus.bValid_i = b.vld; bus.bOpCode_i = b.op; bus.bPOp_i = b.p; bus.bSOp_i = b.s;
    bus.bWbAddr_i = b.wb; bus.bIsWb_i = b.iswb;
    #1;
    if (r) begin
      m_rr = 0; busy_end = 0; rq.delete();
      x_en = 0; x_ill = 0; x_iswb = 0; x_op = 0; x_pop = 0; x_sop = 0; x_wb = 0;
    end else begin
      idle = !(e < busy_end);
      ea = idle && a.vld && (!b.vld || m_rr == 1'b0);
      eb = idle && b.vld && (!a.vld || m_rr == 1'b1);
      chk("aReady", 32'(bus.aReady_o), 32'(ea));
      chk("bReady", 32'(bus.bReady_o), 32'(eb));
      g = eb ? b : a;
      x_en = 0; x_ill = 0;
      if (ea || eb) begin
        m_rr = ea;
        if (g.op > 3) x_ill = 1;
        else begin
          x_en = 1; x_op = g.op; x_pop = g.p; x_sop = g.s; x_wb = g.wb; x_iswb = g.iswb;
          if (g.op == 3 && MS > 0) busy_end = e + 1 + MS;
          if (g.op != 0 && g.iswb) rq.push_back('{due: e + 2, own: eb});
        end
      end
    end
    @(posedge clk);
    e++;
    #1;
    chk("auEnable", 32'(bus.auEnable_o), 32'(x_en));
    chk("auOpCode", 32'(bus.auOpCode_o), 32'(x_op));
    chk("auPOp", 32'(bus.auPOp_o), 32'(x_pop));
    chk("auSOp", 32'(bus.auSOp_o), 32'(x_sop));
    chk("auWbAddr", 32'(bus.auWbAddr_o), 32'(x_wb));
    chk("auIsWb", 32'(bus.auIsWb_o), 32'(x_iswb));
    chk("illegalOp", 32'(bus.illegalOp_o), 32'(x_ill));
    chk("busy", 32'(bus.busy_o), 32'(e < busy_end));
    while (rq.size() > 0 && rq[0].due < e) void'(rq.pop_front());
    resv = (rq.size() > 0 && rq[0].due == e);
    own  = resv ? rq[0].own : 1'b0;
    chk("resValid", 32'(bus.resValid_o), 32'(resv));
    if (resv || r) chk("resOwner", 32'(bus.resOwner_o), 32'(own));
  endtask

  req_t idle_r, a_add, b_add;

  initial begin
    bus.aValid_i = 0; bus.aOpCode_i = 0; bus.aPOp_i = 0; bus.aSOp_i = 0;
    bus.aWbAddr_i = 0; bus.aIsWb_i = 0;
    bus.bValid_i = 0; bus.bOpCode_i = 0; bus.bPOp_i = 0; bus.bSOp_i = 0;
    bus.bWbAddr_i = 0; bus.bIsWb_i = 0;
    idle_r = mk(0, 0, 0, 0, 0, 0);
    a_add  = mk(1, 1, 3, 4, 5, 1);
    b_add  = mk(1, 2, 10, 2, 9, 1);

    step(idle_r, idle_r, 1);
    step(idle_r, idle_r, 1);
    // A alone, back-to-back adds
    for (int i = 0; i < 4; i++) step(a_add, idle_r, 0);
    step(idle_r, idle_r, 0);
    step(idle_r, idle_r, 0);
    // Both valid: strict alternation
    for (int i = 0; i < 6; i++) step(a_add, b_add, 0);
    step(idle_r, idle_r, 0);
    step(idle_r, idle_r, 0);
    // Mul from A stalls B for one cycle, then B goes
    step(idle_r, idle_r, 1);
    step(mk(1, 3, 7, 6, 3, 1), b_add, 0);
    step(idle_r, b_add, 0);
    step(idle_r, b_add, 0);
    step(idle_r, idle_r, 0);
    step(idle_r, idle_r, 0);
    // Illegal opcode from B, then a tie
    step(idle_r, mk(1, 9, 1, 1, 1, 1), 0);
    step(idle_r, idle_r, 0);
    step(a_add, b_add, 0);
    step(idle_r, idle_r, 0);
    step(idle_r, idle_r, 0);
    // Reset while BUSY with a tag in flight
    step(mk(1, 3, 2, 2, 4, 1), idle_r, 0);
    step(idle_r, idle_r, 1);
    step(a_add, b_add, 0);
    step(idle_r, idle_r, 0);
    // Nop with writeback
    step(mk(1, 0, 8, 8, 7, 1), idle_r, 0);
    step(idle_r, idle_r, 0);
    step(idle_r, idle_r, 0);

    for (int i = 0; i < 400; i++) begin
      req_t ra, rb;
      int oa, ob;
      oa = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 127)) : int'($urandom_range(0, 3));
      ob = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 127)) : int'($urandom_range(0, 3));
      ra = mk(1'($urandom_range(0, 1)), oa, int'($urandom), int'($urandom),
              int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      rb = mk(1'($urandom_range(0, 1)), ob, int'($urandom), int'($urandom),
              int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      step(ra, rb, ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
